// File: rtl/dff_posedge_async_rst_set_pkg.sv
// -----------------------------------------------------------------------------
// dff_posedge_async_rst_set_pkg
//   Shared constants for the async reset/set flop family. Other blocks that
//   follow the same "reset forces zero, set forces ones" convention can import
//   these instead of repeating literals.
//
//   RST_BIT        : value every bit takes while reset is asserted
//   SET_BIT        : value every bit takes while set is asserted (reset low)
//   ctrl_forcing() : true while either asynchronous control owns the flop
// -----------------------------------------------------------------------------
package dff_posedge_async_rst_set_pkg;

   localparam logic RST_BIT = 1'b0;
   localparam logic SET_BIT = 1'b1;

   // While this is true the clock path is ignored and q is forced.
   function automatic logic ctrl_forcing(input logic rst, input logic set);
      return rst | set;
   endfunction

endpackage : dff_posedge_async_rst_set_pkg

// File: rtl/dff_pe_ar_as_bit.sv
// -----------------------------------------------------------------------------
// dff_pe_ar_as_bit
//   Single-bit positive-edge D flop with asynchronous active-high reset and
//   asynchronous active-high set; reset has priority over set. Intended to map
//   onto a library flop with async clear and preset pins.
//
//   clk : capture clock (rising edge)
//   rst : async reset, forces q to RST_BIT, highest priority
//   set : async set, forces q to SET_BIT when rst is low
//   d   : data input
//   q   : registered output
// -----------------------------------------------------------------------------
module dff_pe_ar_as_bit
   import dff_posedge_async_rst_set_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic d,
   output logic q
);

   logic set_eff;
   logic q_d;
   logic q_q;

   // The preset pin only sees set when reset is low. This gives reset its
   // priority at the pin level and, when rst falls while set is still high,
   // produces a fresh rising edge on set_eff so q goes to ones immediately
   // without waiting for a clock.
   assign set_eff = set & ~rst;

   assign q_d = d;

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // its inputs before any of them change in the same timestep.
   always_ff @(posedge clk or posedge rst or posedge set_eff) begin
      if (rst) begin
         q_q <= RST_BIT;
      end else if (set_eff) begin
         q_q <= SET_BIT;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : dff_pe_ar_as_bit

// File: rtl/dff_posedge_async_rst_set.sv
// -----------------------------------------------------------------------------
// dff_posedge_async_rst_set
//   WIDTH-bit positive-edge D flop with asynchronous active-high reset and set.
//   Priority: rst (q = 0) > set (q = all ones) > rising clk edge (q <= d).
//   Built from one dff_pe_ar_as_bit per bit so each bit maps directly onto a
//   library async set/reset flop. rst and set are used as-is; upstream logic is
//   responsible for releasing them cleanly with respect to clk.
//
//   WIDTH : data width, must be >= 1
//   clk   : capture clock (rising edge)
//   rst   : async reset, q -> all zeros
//   set   : async set,   q -> all ones (ignored while rst is high)
//   d     : data input [WIDTH-1:0]
//   q     : registered output [WIDTH-1:0]
// -----------------------------------------------------------------------------
module dff_posedge_async_rst_set
   import dff_posedge_async_rst_set_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (WIDTH < 1) begin : g_bad_width
      $error("dff_posedge_async_rst_set: WIDTH must be >= 1");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_pe_ar_as_bit u_bit (
         .clk (clk),
         .rst (rst),
         .set (set),
         .d   (d[i]),
         .q   (q[i])
      );
   end

`ifndef SYNTHESIS
   // Sampled at clock edges: a control that was high going into the edge must
   // already have forced q.
   a_rst_forces_zero : assert property (
      @(posedge clk) rst |-> (q == {WIDTH{RST_BIT}})
   );

   a_set_forces_ones : assert property (
      @(posedge clk) (set && !rst) |-> (q == {WIDTH{SET_BIT}})
   );

   // With no control active at this edge or the previous one, q must hold
   // exactly what d was at the previous edge.
   a_data_follows_d : assert property (
      @(posedge clk) disable iff (ctrl_forcing(rst, set))
      $past(!ctrl_forcing(rst, set)) |-> (q == $past(d))
   );
`endif

endmodule : dff_posedge_async_rst_set

// File: tb/tb_dff_posedge_async_rst_set.sv
// -----------------------------------------------------------------------------
// tb_dff_posedge_async_rst_set
//   Drives a 1-bit and an 8-bit instance. Expected q values are pushed to a
//   queue when stimulus is applied and popped when q is sampled.
// -----------------------------------------------------------------------------
module tb_dff_posedge_async_rst_set;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, set1;
   logic [0:0] d1, q1;
   logic       rst8, set8;
   logic [7:0] d8, q8;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];

   dff_posedge_async_rst_set #(.WIDTH(1)) u_dut1 (
      .clk (clk),
      .rst (rst1),
      .set (set1),
      .d   (d1),
      .q   (q1)
   );

   dff_posedge_async_rst_set #(.WIDTH(8)) u_dut8 (
      .clk (clk),
      .rst (rst8),
      .set (set8),
      .d   (d8),
      .q   (q8)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: q=%h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic sb_push(input logic [7:0] e);
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      if (exp_q.size() == 0) e = 'x;
      else                   e = exp_q.pop_front();
      check(tag, obs, e);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       m1, v1;
      logic [7:0] m8, v8;

      rst1 = 1'b0; set1 = 1'b0; d1 = 1'b0;
      rst8 = 1'b0; set8 = 1'b0; d8 = 8'h00;

      // Scenario 1: set forces ones immediately and holds over edges.
      #1;
      set1 = 1'b1;
      rst8 = 1'b1;
      sb_push(8'h01);
      sb_push(8'h00);
      #1;
      sb_check("s1_set_immediate", 8'(q1));
      sb_check("s8_rst_initial", q8);
      repeat (2) @(posedge clk);
      sb_push(8'h01);
      #1 sb_check("s1_set_holds_over_edges", 8'(q1));

      // Scenario 2: release set, then data follows d one edge later.
      @(negedge clk);
      set1 = 1'b0; d1 = 1'b0;
      sb_push(8'h01);
      #1 sb_check("s2_set_release_holds", 8'(q1));
      @(posedge clk);
      sb_push(8'h00);
      #1 sb_check("s2_capture_d0", 8'(q1));
      @(negedge clk);
      d1 = 1'b1;
      sb_push(8'h00);
      #1 sb_check("s2_no_early_update", 8'(q1));
      @(posedge clk);
      sb_push(8'h01);
      #1 sb_check("s2_capture_d1", 8'(q1));

      // Scenario 3: mid-cycle reset is immediate and blocks d.
      @(negedge clk);
      #2 rst1 = 1'b1;
      sb_push(8'h00);
      #1 sb_check("s3_rst_async", 8'(q1));
      d1 = 1'b0;
      @(posedge clk);
      sb_push(8'h00);
      #1 sb_check("s3_rst_blocks_d0", 8'(q1));
      @(negedge clk);
      d1 = 1'b1;
      @(posedge clk);
      sb_push(8'h00);
      #1 sb_check("s3_rst_blocks_d1", 8'(q1));

      // Scenario 4: reset beats set; reset falling with set high gives ones.
      @(negedge clk);
      set1 = 1'b1;
      sb_push(8'h00);
      #1 sb_check("s4_rst_beats_set", 8'(q1));
      @(posedge clk);
      sb_push(8'h00);
      #1 sb_check("s4_both_over_edge", 8'(q1));
      @(negedge clk);
      #2 rst1 = 1'b0;
      sb_push(8'h01);
      #1 sb_check("s4_rst_fall_set_high", 8'(q1));
      @(negedge clk);
      set1 = 1'b0; d1 = 1'b0;
      sb_push(8'h01);
      #1 sb_check("s4_set_release_holds", 8'(q1));
      @(posedge clk);
      sb_push(8'h00);
      #1 sb_check("s4_follow_d", 8'(q1));

      // Scenario 5: reset released between edges waits for the next edge.
      @(negedge clk);
      d1 = 1'b1; rst1 = 1'b1;
      sb_push(8'h00);
      #1 sb_check("s5_rst", 8'(q1));
      @(posedge clk);
      @(negedge clk);
      #2 rst1 = 1'b0;
      sb_push(8'h00);
      #1 sb_check("s5_release_holds", 8'(q1));
      @(posedge clk);
      sb_push(8'h01);
      #1 sb_check("s5_capture_after_release", 8'(q1));
      m1 = 1'b1;

      // Random data on the 1-bit instance with a d glitch between edges.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         v1 = 1'($urandom_range(0, 1));
         d1 = ~v1;
         sb_push(8'(m1));
         #1 sb_check("r1_glitch_hold", 8'(q1));
         d1 = v1;
         m1 = v1;
         sb_push(8'(m1));
         @(posedge clk);
         #1 sb_check("r1_capture", 8'(q1));
      end

      // Scenario 6: 8-bit set, capture, async reset.
      @(negedge clk);
      rst8 = 1'b0;
      @(negedge clk);
      set8 = 1'b1;
      sb_push(8'hFF);
      #1 sb_check("s6_set_ff", q8);
      @(posedge clk);
      sb_push(8'hFF);
      #1 sb_check("s6_set_over_edge", q8);
      @(negedge clk);
      set8 = 1'b0; d8 = 8'hA5;
      sb_push(8'hFF);
      #1 sb_check("s6_set_release_holds", q8);
      @(posedge clk);
      sb_push(8'hA5);
      #1 sb_check("s6_capture_a5", q8);
      @(negedge clk);
      #2 rst8 = 1'b1;
      sb_push(8'h00);
      #1 sb_check("s6_rst_async", q8);

      // Random data on the 8-bit instance.
      @(negedge clk);
      rst8 = 1'b0; d8 = 8'h3C;
      sb_push(8'h00);
      #1 sb_check("r8_release_holds", q8);
      @(posedge clk);
      sb_push(8'h3C);
      #1 sb_check("r8_first_capture", q8);
      m8 = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         v8 = 8'($urandom);
         d8 = ~v8;
         sb_push(m8);
         #1 sb_check("r8_glitch_hold", q8);
         d8 = v8;
         m8 = v8;
         sb_push(m8);
         @(posedge clk);
         #1 sb_check("r8_capture", q8);
      end

      check("sb_leftover", 8'(exp_q.size()), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_dff_posedge_async_rst_set
